// File: rtl/core_test_monitor.sv
// rtl/core_test_monitor.sv - holds a core in reset, then watches its tohost writes for pass/fail/timeout
// Optional write counter output enabled by CORE_TEST_MONITOR_WRCOUNT_EN.
module core_test_monitor #(
  parameter int unsigned       RESET_CYCLES   = 1,
  parameter int unsigned       TIMEOUT_CYCLES = 30,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              core_reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic [31:0]       cycle_count
`ifdef CORE_TEST_MONITOR_WRCOUNT_EN
  ,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_PASS    = 3'd2;
  localparam logic [2:0] S_FAIL    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [2:0]  state;
  logic [31:0] hold_cnt;
  logic        hit;
  logic        is_pass;
  logic        is_fail;
  logic        to_hit;

  assign hit     = (state == S_RUN) && wr_en && (wr_addr == TOHOST_ADDR);
  assign is_pass = (wr_data == DATA_W'(1));
  assign is_fail = wr_data[0] && !is_pass;
  assign to_hit  = TO_EN && (cycle_count == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_HOLD;
      hold_cnt    <= 32'(RESET_CYCLES);
      core_reset  <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == 32'd0) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 32'd1;
          end
        end
        S_RUN: begin
          // A pass/fail write on the timeout cycle takes priority over the timeout.
          if (hit && is_pass) begin
            state      <= S_PASS;
            pass       <= 1'b1;
            done       <= 1'b1;
            core_reset <= 1'b1;
          end else if (hit && is_fail) begin
            state      <= S_FAIL;
            fail       <= 1'b1;
            done       <= 1'b1;
            core_reset <= 1'b1;
            fail_code  <= wr_data[DATA_W-1:1];
          end else if (to_hit) begin
            state      <= S_TIMEOUT;
            timeout    <= 1'b1;
            done       <= 1'b1;
            core_reset <= 1'b1;
          end else if (cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CORE_TEST_MONITOR_WRCOUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count <= '0;
    end else if ((state == S_RUN) && wr_en && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule
